// File: rtl/arb_pkg.sv
// Shared types and helpers for the lockable round-robin / fixed-priority arbiter.
// Request vectors up to MaxReqW bits are supported by the helper functions.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MaxReqW = 64;

  // A zero hold limit still needs a 1-bit counter so the datapath stays well-formed.
  function automatic int unsigned hold_cnt_width(input int unsigned max_hold);
    return (max_hold == 32'd0) ? 32'd1 : 32'($clog2(max_hold + 32'd1));
  endfunction

  // Lowest set bit of v; zero in gives zero out.
  function automatic logic [MaxReqW-1:0] ff(input logic [MaxReqW-1:0] v);
    logic [MaxReqW-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return v & ~(v - one);
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MaxReqW-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxReqW; i++) begin
      if (v[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Priority picker: lowest set bit of the masked request vector when that is nonzero,
// otherwise lowest set bit of the full request vector.
module prio_pick
  import arb_pkg::*;
#(
  parameter int unsigned REQ_WIDTH = 16,
  localparam int unsigned IdxW     = $clog2(REQ_WIDTH)
) (
  input  logic [REQ_WIDTH-1:0] req,
  input  logic [REQ_WIDTH-1:0] mask,
  input  logic                 use_mask,
  output logic [REQ_WIDTH-1:0] pick,
  output logic [IdxW-1:0]      pick_idx
);

  logic [MaxReqW-1:0] req_ext;
  logic [MaxReqW-1:0] masked_ext;
  logic [MaxReqW-1:0] pick_ext;

  always_comb begin
    req_ext                   = '0;
    req_ext[REQ_WIDTH-1:0]    = req;
    masked_ext                = '0;
    masked_ext[REQ_WIDTH-1:0] = req & mask;

    if (use_mask && (|masked_ext)) begin
      pick_ext = ff(masked_ext);
    end else begin
      pick_ext = ff(req_ext);
    end

    pick     = pick_ext[REQ_WIDTH-1:0];
    pick_idx = IdxW'(onehot_to_idx(pick_ext));
  end

endmodule

// File: rtl/rr_arbiter_lock.sv
// Registered arbiter that locks a grant until ack, withdrawal or hold-limit expiry, and
// re-arbitrates in the release cycle so consecutive owners see no idle bubble.
module rr_arbiter_lock
  import arb_pkg::*;
#(
  parameter int unsigned REQ_WIDTH   = 16,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned MAX_HOLD    = 0,
  localparam int unsigned IdxW       = $clog2(REQ_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_WIDTH-1:0] req,
  input  logic                 ack,
  output logic [REQ_WIDTH-1:0] grant,
  output logic                 grant_valid,
  output logic [IdxW-1:0]      grant_idx
);

  localparam int unsigned HoldW          = hold_cnt_width(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldLimit = HoldW'(MAX_HOLD - 32'd1);
  localparam logic [IdxW-1:0] LastRst    = IdxW'(REQ_WIDTH - 32'd1);

  arb_state_e           state_q, state_d;
  logic [REQ_WIDTH-1:0] grant_q, grant_d;
  logic [IdxW-1:0]      grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;

  logic [REQ_WIDTH-1:0] req_eff;
  logic [REQ_WIDTH-1:0] mask;
  logic [REQ_WIDTH-1:0] pick;
  logic [IdxW-1:0]      pick_idx;
  logic                 owner_req;
  logic                 hold_hit;
  logic                 release_ev;

  // The owner is never a candidate on release; in IDLE grant_q is zero so req passes through.
  always_comb begin
    req_eff = req & ~grant_q;
    mask    = '0;
    for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
      mask[i] = (i > 32'(last_q));
    end
  end

  prio_pick #(
    .REQ_WIDTH(REQ_WIDTH)
  ) u_prio_pick (
    .req     (req_eff),
    .mask    (mask),
    .use_mask(ROUND_ROBIN != 0),
    .pick    (pick),
    .pick_idx(pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;

    owner_req  = |(req & grant_q);
    hold_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HoldLimit);
    release_ev = ack || !owner_req || hold_hit;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d     = pick;
          grant_idx_d = pick_idx;
          last_d      = pick_idx;
          hold_cnt_d  = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (release_ev) begin
          if (|pick) begin
            grant_d     = pick;
            grant_idx_d = pick_idx;
            last_d      = pick_idx;
            hold_cnt_d  = '0;
          end else if (hold_hit && owner_req) begin
            // Nobody else is waiting, so an expired owner keeps the grant.
            hold_cnt_d = '0;
          end else begin
            grant_d     = '0;
            grant_idx_d = '0;
            hold_cnt_d  = '0;
            state_d     = IDLE;
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: begin
        grant_d     = '0;
        grant_idx_d = '0;
        hold_cnt_d  = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_q      <= LastRst;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Directed bench: three 4-requester arbiters (RR, fixed priority, RR with hold limit 3).
module tb_rr_arbiter_lock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req_rr, req_fx, req_hl;
  logic       ack_rr, ack_fx, ack_hl;
  logic [3:0] grant_rr, grant_fx, grant_hl;
  logic       gv_rr, gv_fx, gv_hl;
  logic [1:0] idx_rr, idx_fx, idx_hl;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [3:0] rot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  rr_arbiter_lock #(.REQ_WIDTH(4), .ROUND_ROBIN(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rst(rst), .req(req_rr), .ack(ack_rr),
    .grant(grant_rr), .grant_valid(gv_rr), .grant_idx(idx_rr)
  );

  rr_arbiter_lock #(.REQ_WIDTH(4), .ROUND_ROBIN(0), .MAX_HOLD(0)) u_fx (
    .clk(clk), .rst(rst), .req(req_fx), .ack(ack_fx),
    .grant(grant_fx), .grant_valid(gv_fx), .grant_idx(idx_fx)
  );

  rr_arbiter_lock #(.REQ_WIDTH(4), .ROUND_ROBIN(1), .MAX_HOLD(3)) u_hl (
    .clk(clk), .rst(rst), .req(req_hl), .ack(ack_hl),
    .grant(grant_hl), .grant_valid(gv_hl), .grant_idx(idx_hl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    return {oh[2] | oh[3], oh[1] | oh[3]};
  endfunction

  task automatic expect_grant(input string tag, input int dut, input logic [3:0] exp);
    logic [3:0] g;
    logic       v;
    logic [1:0] ix;
    case (dut)
      0:       begin g = grant_rr; v = gv_rr; ix = idx_rr; end
      1:       begin g = grant_fx; v = gv_fx; ix = idx_fx; end
      default: begin g = grant_hl; v = gv_hl; ix = idx_hl; end
    endcase
    check({tag, "_grant"}, 32'(g), 32'(exp));
    check({tag, "_valid"}, 32'(v), 32'(|exp));
    check({tag, "_idx"}, 32'(ix), 32'(idx_of(exp)));
  endtask

  initial begin
    rst    = 1'b1;
    req_rr = '0; req_fx = '0; req_hl = '0;
    ack_rr = 1'b0; ack_fx = 1'b0; ack_hl = 1'b0;
    step();
    step();
    expect_grant("rst_rr", 0, 4'b0000);
    expect_grant("rst_fx", 1, 4'b0000);
    expect_grant("rst_hl", 2, 4'b0000);
    rst = 1'b0;

    // Rotation with ack every second cycle.
    req_rr = 4'b1111;
    step();
    expect_grant("rot_first", 0, rot[0]);
    for (int i = 1; i < 5; i++) begin
      ack_rr = 1'b0;
      step();
      expect_grant("rot_hold", 0, rot[i-1]);
      ack_rr = 1'b1;
      step();
      expect_grant("rot_next", 0, rot[i]);
    end

    // Withdrawal hands over, then all-zero request goes idle.
    req_rr = 4'b0100; ack_rr = 1'b1;
    step();
    expect_grant("wd_owner", 0, 4'b0100);
    req_rr = 4'b0001; ack_rr = 1'b0;
    step();
    expect_grant("wd_handover", 0, 4'b0001);
    req_rr = 4'b0000;
    step();
    expect_grant("wd_idle", 0, 4'b0000);

    // Reset mid-grant, then last must be back at 3.
    req_rr = 4'b1001;
    step();
    expect_grant("rs_pre", 0, 4'b1000);
    rst = 1'b1;
    step();
    expect_grant("rs_clear", 0, 4'b0000);
    rst = 1'b0;
    step();
    expect_grant("rs_after", 0, 4'b0001);
    req_rr = 4'b0100;
    step();
    expect_grant("rs2_pre", 0, 4'b0100);
    rst = 1'b1; req_rr = 4'b1001;
    step();
    expect_grant("rs2_clear", 0, 4'b0000);
    rst = 1'b0;
    step();
    expect_grant("rs2_last", 0, 4'b0001);
    req_rr = 4'b0000;

    // Fixed priority: owner excluded on release.
    req_fx = 4'b1010;
    step();
    expect_grant("fx_first", 1, 4'b0010);
    ack_fx = 1'b1;
    step();
    expect_grant("fx_alt1", 1, 4'b1000);
    step();
    expect_grant("fx_alt2", 1, 4'b0010);
    ack_fx = 1'b0; req_fx = 4'b0000;
    step();
    expect_grant("fx_idle", 1, 4'b0000);
    req_fx = 4'b1011;
    step();
    expect_grant("fx_lowest", 1, 4'b0001);
    ack_fx = 1'b1;
    step();
    expect_grant("fx_next", 1, 4'b0010);
    step();
    expect_grant("fx_noprot", 1, 4'b0001);
    ack_fx = 1'b0; req_fx = 4'b0000;

    // Hold limit 3 with two requesters, then a lone requester.
    req_hl = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_grant("hl_a", 2, 4'b0001);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      expect_grant("hl_b", 2, 4'b0010);
    end
    step();
    expect_grant("hl_back", 2, 4'b0001);
    req_hl = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      expect_grant("hl_alone", 2, 4'b0001);
    end

    // Simultaneous ack, withdrawal and limit: one re-arbitration, counter cleared.
    req_hl = 4'b0100;
    step();
    expect_grant("sim_owner", 2, 4'b0100);
    req_hl = 4'b1100;
    step();
    expect_grant("sim_h1", 2, 4'b0100);
    step();
    expect_grant("sim_h2", 2, 4'b0100);
    ack_hl = 1'b1; req_hl = 4'b1000;
    step();
    expect_grant("sim_rel", 2, 4'b1000);
    ack_hl = 1'b0; req_hl = 4'b1100;
    step();
    expect_grant("sim_cnt1", 2, 4'b1000);
    step();
    expect_grant("sim_cnt2", 2, 4'b1000);
    step();
    expect_grant("sim_expire", 2, 4'b0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_lock.md
# rr_arbiter_lock

Registered, parametrised arbiter granting one of `REQ_WIDTH` requesters, with a selectable fixed-priority or round-robin policy.

- A grant is held (locked) until the owner signals completion, withdraws its request, or exceeds a hold limit.
- Arbitration is re-run in the release cycle, so back-to-back grants have no bubble.
- It sits in front of shared resources (bus ports, memory banks) where a combinational lowest-index priority picker would starve high-index requesters.

## Interface

Parameters:

- `REQ_WIDTH`, 16: number of requesters; must be ≥ 2.
- `ROUND_ROBIN`, 1: 1 selects round-robin; 0 selects fixed priority (bit 0 highest).
- `MAX_HOLD`, 0: maximum cycles one grant may be held; 0 disables the limit.

Ports:

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in `REQ_WIDTH`: request vector; level-sensitive, one bit per requester.
- `ack` in 1: owner completes its transaction; ignored while `grant_valid`=0.
- `grant` out `REQ_WIDTH`: registered one-hot grant, or all zero.
- `grant_valid` out 1: equals `|grant`.
- `grant_idx` out `$clog2(REQ_WIDTH)`: binary index of the granted bit; 0 when idle.

## Operation

- **States:** IDLE (no grant) and BUSY (one grant locked). Held in an enum from the package.
- **Pick function:** `ff(v) = v & ~(v-1)`, i.e. the lowest set bit of `v`.
  - Fixed mode: `pick = ff(req)`.
  - RR mode: `mask` has 1s strictly above `last`. `pick = ff(req & mask)` when that is nonzero, else `ff(req)`.
- **`last` register:** holds the index of the most recent winner. Reset value is `REQ_WIDTH-1`, so bit 0 has highest priority after reset. `last` is updated only when a new grant is issued.
- **IDLE:**
  - `req`=0: stay in IDLE.
  - Otherwise: `grant <= pick`, `last <=` index of `pick`, clear `hold_cnt`, go to BUSY.
- **BUSY:** a release event is any of the following:
  - (a) `ack`=1;
  - (b) `req[grant_idx]`=0 (the owner withdrew);
  - (c) `MAX_HOLD`≠0 and `hold_cnt == MAX_HOLD-1`.
- **On release:** compute `pick` from `req` with the owner's bit cleared.
  - Nonzero: grant it, update `last`, clear `hold_cnt`, stay in BUSY (back-to-back).
  - Zero and release cause is (c) with the owner still requesting: re-grant the owner and clear `hold_cnt`. The owner is not starved when alone.
  - Zero otherwise: clear `grant`, go to IDLE.
- **Without release:** `grant` is unchanged and `hold_cnt` increments. `hold_cnt` saturates and never wraps.
- **Simultaneous events:** (a), (b) and (c) together are one release. In fixed mode the owner's bit is still excluded on release.
- **Mid-cycle changes:** new requests arriving in BUSY never preempt the owner.
- **`hold_cnt` width:** `$clog2(MAX_HOLD+1)`, minimum 1 bit.

## Timing

- **Reset:** `grant`=0, `grant_valid`=0, `grant_idx`=0, `last`=`REQ_WIDTH-1`, `hold_cnt`=0, state IDLE.
  - Reset asserted in BUSY clears `grant` at the next edge.
  - `ack` in the reset cycle is ignored.
- **Latency:** `req` rising in IDLE in cycle t gives `grant` in cycle t+1.
  - Release in cycle t gives the next owner's grant in cycle t+1; zero idle cycles between owners.
- **Hold limit:** with `MAX_HOLD`=M, an owner that never acks holds `grant` for exactly M cycles.
- **Outputs:** all outputs are registered; there is no combinational path from `req`/`ack` to the outputs.

## Structure

- **Package `arb_pkg`:** `arb_state_e` {IDLE, BUSY}; the `ff`/one-hot-to-index helper function; the `clog2` guard constant for `hold_cnt` width.
- **Sub-module `prio_pick`:** parametrised `REQ_WIDTH`. Inputs `req`, `mask`, `use_mask`; outputs one-hot `pick` and `pick_idx`. Instantiated once, with the owner bit cleared by the parent.
- **Top:** the state register, `last`, `hold_cnt`, and the grant register.

## Test plan

All scenarios use `REQ_WIDTH`=4.

1. **Rotation, RR, `MAX_HOLD`=0:**
   - Stimulus: `req`=4'b1111, `ack` pulsed every 2nd cycle.
   - Required: `grant` sequence 0001, 0010, 0100, 1000, 0001, each change one cycle after `ack`; no idle cycle between grants.
2. **Fixed mode, `ROUND_ROBIN`=0:**
   - Stimulus: `req`=4'b1010, ack each grant.
   - Required: grants alternate 0010, 1000, 0010, because the owner is excluded on release.
   - Stimulus: `req`=4'b1011.
   - Required: the first grant is 0001.
3. **Withdrawal:**
   - Stimulus: owner 0100 drops `req[2]` with `ack`=0 and `req`=4'b0001.
   - Required: next cycle `grant`=0001.
   - Stimulus: then `req` goes to all zero.
   - Required: `grant`=0, `grant_valid`=0 one cycle later.
4. **Hold limit, `MAX_HOLD`=3:**
   - Stimulus: `req`=4'b0011, no `ack`.
   - Required: 0001 held exactly 3 cycles, then 0010 for 3 cycles, then 0001.
   - Stimulus: only `req[0]` asserted.
   - Required: 0001 is re-granted continuously with no gap.
5. **Reset mid-grant:**
   - Stimulus: `rst`=1 while `grant`=1000.
   - Required: next edge all outputs are 0.
   - Stimulus: after reset, `req`=4'b1001.
   - Required: grant is 0001, confirming `last` was restored to 3.
6. **Simultaneous release:**
   - Stimulus: `ack`=1 and owner `req` drop in the same cycle as the `hold_cnt` limit, with `req`=4'b1100 (owner 0100).
   - Required: a single re-arbitration producing `grant`=1000 next cycle, with `hold_cnt` cleared.
